// File: rtl/dds_dac_pkg.sv
// Shared types and constants for the DAC SPI output stage of the DDS chain.
// Frame layout is {config nibble, 12-bit sample}, sent MSB first.
package dds_dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        STOP,
        LDAC
    } dac_state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int CFG_W      = FRAME_BITS - DATA_BITS;
    localparam int OVF_W      = 8;

    // Channel A, unbuffered, gain 1x, active
    localparam logic [CFG_W-1:0] CFG_BITS_DEF = 4'b0011;

endpackage

// File: rtl/dac_tick_gen.sv
// Half-period timebase for the SPI serialiser: emits a one-cycle tick every
// CLK_DIV clocks, and restarts from zero whenever restart is held.
module dac_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic Fg_CLK,
    input  logic RESETn,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dac_spi_driver.sv
// Serialises each interpolated sample to a 12-bit SPI DAC as a 16-bit frame,
// then pulses LDACn; a one-deep pending register absorbs mid-frame samples.
module dac_spi_driver
    import dds_dac_pkg::*;
#(
    parameter int               CLK_DIV  = 2,
    parameter logic [CFG_W-1:0] CFG_BITS = CFG_BITS_DEF
) (
    input  logic                 Fg_CLK,
    input  logic                 RESETn,
    input  logic                 Enable,
    input  logic [DATA_BITS-1:0] osc_out,
    output logic                 DAC_CSn,
    output logic                 DAC_SCLK,
    output logic                 DAC_SDI,
    output logic                 DAC_LDACn,
    output logic                 Busy,
    output logic                 Overrun,
    output logic [OVF_W-1:0]     OvfCnt
);

    localparam int BIT_W = $clog2(FRAME_BITS);

    dac_state_t              state;
    logic                    pend_valid;
    logic [DATA_BITS-1:0]    pend_data;
    logic [FRAME_BITS-1:0]   shreg;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    phase_hi;
    logic                    tick;
    logic                    consume;
    logic                    shift_now;
    logic                    ovr_now;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counter is parked in IDLE so every frame starts on a fresh half-period;
    // all later state entries coincide with a tick wrap.
    dac_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .Fg_CLK  (Fg_CLK),
        .RESETn  (RESETn),
        .restart (state == IDLE),
        .tick    (tick)
    );

    assign consume   = (state == IDLE) && pend_valid;
    assign shift_now = (state == SHIFT) && tick && phase_hi;
    assign ovr_now   = Enable && pend_valid && !consume;

    // Data path: no reset needed, validity is tracked by pend_valid and state
    always_ff @(posedge Fg_CLK) begin
        if (Enable) begin
            pend_data <= osc_out;
        end
        if (consume) begin
            shreg <= {CFG_BITS, pend_data};
        end else if (shift_now) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            phase_hi   <= 1'b0;
            bit_cnt    <= '0;
            DAC_CSn    <= 1'b1;
            DAC_SCLK   <= 1'b0;
            DAC_SDI    <= 1'b0;
            DAC_LDACn  <= 1'b1;
            Busy       <= 1'b0;
            Overrun    <= 1'b0;
            OvfCnt     <= '0;
        end else begin
            // Pins are decoded from the current state, one cycle behind it
            DAC_CSn   <= !((state == SETUP) || (state == SHIFT));
            DAC_SCLK  <= (state == SHIFT) && phase_hi;
            DAC_SDI   <= ((state == SETUP) || (state == SHIFT)) ? shreg[FRAME_BITS-1] : 1'b0;
            DAC_LDACn <= (state != LDAC);
            Busy      <= (state != IDLE);
            Overrun   <= ovr_now;
            if (ovr_now) begin
                OvfCnt <= sat_inc(OvfCnt);
            end

            pend_valid <= Enable || (pend_valid && !consume);

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state    <= SHIFT;
                        phase_hi <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (phase_hi) begin
                            phase_hi <= 1'b0;
                        end else if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            phase_hi <= 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= LDAC;
                    end
                end
                LDAC: begin
                    if (tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
Downstream stage of the interpolator. Captures each 12-bit interpolated sample (osc_out) on the Enable strobe and serialises it to an external 12-bit SPI DAC as a 16-bit frame: 4 config bits, then 12 data bits, MSB first. After each frame it pulses LDACn so the DAC output updates on the sample clock. A one-deep pending register absorbs a sample that arrives mid-frame; overruns are flagged and counted.

Parameters:
CLK_DIV, 2, SCLK half-period in Fg_CLK cycles (legal range 1..255)
CFG_BITS, 4'b0011, frame bits [15:12] (channel A, unbuffered, gain 1x, active)

Ports:
Fg_CLK  in  1  system clock (24 MHz)
RESETn  in  1  synchronous active-low reset
Enable  in  1  one-cycle sample strobe, aligned with valid osc_out
osc_out  in  12  interpolated sample, unsigned
DAC_CSn  out  1  SPI chip select, active low
DAC_SCLK  out  1  SPI clock, idle low, DAC samples SDI on rising edge
DAC_SDI  out  1  SPI data
DAC_LDACn  out  1  DAC latch strobe, active low
Busy  out  1  high from first CSn-low cycle through last LDACn-low cycle
Overrun  out  1  one-cycle pulse when a pending sample is overwritten
OvfCnt  out  8  saturating overrun count

Behaviour:
- Clock and reset: one clock (Fg_CLK). Reset (RESETn) is synchronous and active-low.
- Reset values: DAC_CSn=1, DAC_SCLK=0, DAC_SDI=0, DAC_LDACn=1, Busy=0, Overrun=0, OvfCnt=0. Pending register cleared, state IDLE. All outputs are registered.
- Capture: on a cycle with Enable=1, latch osc_out into pend_data and set pend_valid.
- Overrun: Enable=1 while pend_valid=1 and IDLE is not consuming the pending sample in that same cycle:
  - the new sample overwrites pend_data;
  - Overrun pulses for 1 cycle;
  - OvfCnt increments and saturates at 255.
- Simultaneous consume and capture: IDLE consumes the pending sample and Enable=1 in the same cycle. The new sample lands in pend_data, pend_valid stays 1, no overrun.
- FSM (half-period tick every CLK_DIV cycles; tick counter restarts on every state entry):
  - IDLE: if pend_valid, load shreg={CFG_BITS,pend_data}, clear pend_valid, go to SETUP.
  - SETUP: CSn=0, SCLK=0, SDI=shreg[15]. Lasts 1 half-period, then SHIFT.
  - SHIFT: 16 bits, each bit = SCLK high for 1 half-period, then low for 1 half-period.
    - At each high-to-low transition, shift shreg left so SDI presents the next bit.
    - After the 16th low phase, go to STOP.
  - STOP: CSn=1, SCLK=0, SDI=0. Lasts 1 half-period, then LDAC.
  - LDAC: LDACn=0 for 1 half-period, then IDLE (LDACn=1).
- Latency: Enable sampled at edge N → DAC_CSn low after edge N+2 (capture at N, IDLE load at N+1, registered output at N+2).
- Frame length: Busy high for 35*CLK_DIV cycles; at least 1 IDLE cycle between frames. At CLK_DIV=2 that is 70 busy cycles, minimum 71-cycle sample period.
- Reset mid-frame: outputs return to reset values at the next edge. No LDACn pulse is issued, so the DAC discards the partial frame. The pending sample is dropped.
- Enable is ignored while RESETn=0.

Decomposition:
- Package dds_dac_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, STOP, LDAC};
  - FRAME_BITS=16, DATA_BITS=12;
  - default CFG_BITS;
  - OvfCnt width.
- Sub-module dac_tick_gen: a CLK_DIV half-period counter with a synchronous restart input, producing a 1-cycle tick. The FSM, shifter and pending register stay in dac_spi_driver.

Test Plan:
- Reset: hold RESETn=0 for 10 cycles → CSn=1, SCLK=0, SDI=0, LDACn=1, Busy=0, OvfCnt=0. Enable pulses during reset produce no frame.
- Single sample: CLK_DIV=2, osc_out=12'hA5C with one Enable pulse.
  - SDI sampled on 16 SCLK rises = 16'h3A5C.
  - CSn low for 66 cycles, LDACn low for 2 cycles, Busy high for 70 cycles.
  - CSn falls 2 edges after Enable.
- Back-to-back: Enable every 71 cycles with 12'h000 then 12'hFFF → frames 16'h3000 and 16'h3FFF, one IDLE cycle between them, OvfCnt=0.
- Overrun: Enable with 12'h111, then 12'h222 and 12'h333 at +10 and +20 cycles.
  - Frame 1 = 16'h3111, frame 2 = 16'h3333.
  - One Overrun pulse; OvfCnt=1.
- Reset mid-frame: assert RESETn=0 for 1 cycle after the 8th SCLK rise.
  - CSn=1 next cycle, no LDACn pulse.
  - Then Enable with 12'h800 → clean frame 16'h3800.
- Saturation: 300 overrun events → OvfCnt=255 and holds; Overrun still pulses each time.
